pipeline_tx_queue: RTL

//  Transmit-side counterpart of the four-direction receive pipeline stage.

---
 rtl/pipeline_tx_queue_if.sv | 36 +++
 rtl/pipeline_tx_queue.sv | 87 ++++++++
 2 files changed

// File: rtl/pipeline_tx_queue_if.sv
// Link bundle for the four-lane transmit queue.
// Router-core group input, per-lane link outputs and status.
interface pipeline_tx_queue_if #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_mask;
    logic [WIDTH-1:0] nin;
    logic [WIDTH-1:0] sin;
    logic [WIDTH-1:0] ein;
    logic [WIDTH-1:0] win;
    logic [WIDTH-1:0] nty;
    logic [WIDTH-1:0] sty;
    logic [WIDTH-1:0] ety;
    logic [WIDTH-1:0] wty;
    logic [3:0]       ty_valid;
    logic [3:0]       ty_ready;
    logic [4*CW-1:0]  lane_cnt;
    logic [3:0]       lane_stall;

    modport master (
        output in_valid, in_mask, nin, sin, ein, win, ty_ready,
        input  in_ready, nty, sty, ety, wty, ty_valid,
        input  lane_cnt, lane_stall
    );

    modport slave (
        input  in_valid, in_mask, nin, sin, ein, win, ty_ready,
        output in_ready, nty, sty, ety, wty, ty_valid,
        output lane_cnt, lane_stall
    );
endinterface

// File: rtl/pipeline_tx_queue.sv
// Four-lane transmit queue: one FIFO per direction (N/S/E/W),
// group push from the router core, independent valid/ready drain.
module pipeline_tx_queue #(
    parameter int WIDTH     = 10,
    parameter int DEPTH     = 4,
    parameter int STALL_LIM = 16
) (
    input logic clk,
    input logic rst,
    pipeline_tx_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STALL_LIM + 1);

    logic [WIDTH-1:0] din  [4];
    logic [WIDTH-1:0] dout [4];
    logic [3:0]       full;
    logic [3:0]       valid;
    logic [3:0]       push;
    logic [3:0]       pop;
    logic             accept;

    assign din[0] = bus.nin;
    assign din[1] = bus.sin;
    assign din[2] = bus.ein;
    assign din[3] = bus.win;

    // Ready only looks at registered counts, so a slot freed by a
    // pop is not reusable until the next cycle.
    assign bus.in_ready = ~|full;
    assign accept       = bus.in_valid & ~|full;

    assign bus.ty_valid = valid;
    assign bus.nty      = dout[0];
    assign bus.sty      = dout[1];
    assign bus.ety      = dout[2];
    assign bus.wty      = dout[3];

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]    wptr;
        logic [PW-1:0]    rptr;
        logic [CW-1:0]    cnt;
        logic [SW-1:0]    stall;

        assign full[g]  = (cnt == CW'(DEPTH));
        assign valid[g] = (cnt != '0);
        assign push[g]  = accept & bus.in_mask[g];
        assign pop[g]   = valid[g] & bus.ty_ready[g];
        assign dout[g]  = valid[g] ? mem[rptr] : '0;

        assign bus.lane_cnt[g*CW +: CW] = cnt;
        assign bus.lane_stall[g]        = (stall == SW'(STALL_LIM));

        // Pointers and occupancy; push+pop keeps the count steady.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
            end else begin
                if (push[g]) wptr <= wptr + PW'(1);
                if (pop[g])  rptr <= rptr + PW'(1);
                if (push[g] && !pop[g])
                    cnt <= cnt + CW'(1);
                else if (pop[g] && !push[g])
                    cnt <= cnt - CW'(1);
            end
        end

        // Flit storage; contents are don't-care until counted.
        always_ff @(posedge clk) begin
            if (push[g]) mem[wptr] <= din[g];
        end

        // Back-pressure duration, saturating at the stall limit.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                stall <= '0;
            else if (pop[g] || !valid[g])
                stall <= '0;
            else if (stall != SW'(STALL_LIM))
                stall <= stall + SW'(1);
        end
    end
endmodule
